// File: rtl/multi_arb_pkg.sv
// Shared definitions for the round-robin multiplier arbiter.
// Optional build macro: MULTI_ARB_STATS_EN (enables the completed-operation counter).
package multi_arb_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Default operand width, matching the existing multiplier
  localparam int DEF_WIDTH = 5;

  // Completed-operation counter width and its saturation value
  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/multi.sv
// Combinational unsigned multiplier: res = a * b at full product width.
module multi #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res
);

  // Extend both operands first so the product is never truncated
  assign res = (2*WIDTH)'(a) * (2*WIDTH)'(b);

endmodule

// File: rtl/multi_arbiter.sv
// Round-robin front end that shares one `multi` instance between NUM_REQ
// requesters and returns the tagged product on a backpressured response port.
// Optional build macro: MULTI_ARB_STATS_EN (op_count_o counts response handshakes,
// saturating; otherwise op_count_o is constant zero and no counter is built).
module multi_arbiter
  import multi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     resp_valid_o,
  output logic [IDW-1:0]           resp_id_o,
  output logic [2*WIDTH-1:0]       resp_res_o,
  input  logic                     resp_ready_i,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         op_count_o
);

  state_e               state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       id_q;
  logic [WIDTH-1:0]     op_a_q;
  logic [WIDTH-1:0]     op_b_q;
  logic [2*WIDTH-1:0]   res_q;

  logic [WIDTH-1:0]     a_slice [NUM_REQ];
  logic [WIDTH-1:0]     b_slice [NUM_REQ];
  logic [2*WIDTH-1:0]   mul_res;
  logic [IDW-1:0]       grant_idx;
  logic [IDW-1:0]       grant_nxt;
  logic                 any_req;
  logic                 accept;

  // First valid requester at or above ptr, wrapping modulo NUM_REQ
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Unpack the flat operand buses into per-requester slices
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_slice[gi] = req_a_i[gi*WIDTH +: WIDTH];
    assign b_slice[gi] = req_b_i[gi*WIDTH +: WIDTH];
  end

  assign any_req   = |req_valid_i;
  assign grant_idx = rr_pick(req_valid_i, rr_ptr_q);
  assign grant_nxt = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Reset gates the handshake so every output reads zero while reset is held
  assign accept = (state_q == ST_IDLE) && any_req && !rst_i;

  // One-hot ready toward the granted requester, only while idle
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = accept && (grant_idx == IDW'(gi));
  end

  multi #(
    .WIDTH(WIDTH)
  ) u_multi (
    .a  (op_a_q),
    .b  (op_b_q),
    .res(mul_res)
  );

  // Controller FSM: grant and capture, multiply, then hold the response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            op_a_q   <= a_slice[grant_idx];
            op_b_q   <= b_slice[grant_idx];
            id_q     <= grant_idx;
            rr_ptr_q <= grant_nxt;
            state_q  <= ST_MUL;
          end
        end
        ST_MUL: begin
          res_q   <= mul_res;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_id_o    = id_q;
  assign resp_res_o   = res_q;
  assign busy_o       = (state_q != ST_IDLE);

`ifdef MULTI_ARB_STATS_EN
  logic             resp_fire;
  logic [CNT_W-1:0] op_count_q;

  assign resp_fire = resp_valid_o && resp_ready_i;

  // Saturating count of completed response handshakes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_count_q <= '0;
    end else if (resp_fire && (op_count_q != CNT_MAX)) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign op_count_o = op_count_q;
`else
  assign op_count_o = '0;
`endif

endmodule

// File: tb/tb_multi_arbiter.sv
// Directed bench for multi_arbiter (NUM_REQ=2, WIDTH=5) with hand-computed results.
module tb_multi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_a;
  logic [9:0]  req_b;
  logic [1:0]  req_ready;
  logic        resp_valid;
  logic [0:0]  resp_id;
  logic [9:0]  resp_res;
  logic        resp_ready;
  logic        busy;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;

  multi_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .resp_valid_o(resp_valid),
    .resp_id_o   (resp_id),
    .resp_res_o  (resp_res),
    .resp_ready_i(resp_ready),
    .busy_o      (busy),
    .op_count_o  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with resp_ready high; req_valid is left as given
  task automatic op(input string tag, input logic [1:0] mask, input logic [1:0] exp_rdy,
                    input logic [0:0] exp_id, input logic [9:0] exp_res);
    req_valid = mask;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    tick();
    chk({tag, ".mul_busy"}, 32'(busy), 32'd1);
    chk({tag, ".mul_valid"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".resp_id"}, 32'(resp_id), 32'(exp_id));
    chk({tag, ".resp_res"}, 32'(resp_res), 32'(exp_res));
    tick();
    chk({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    $display("op %s: id=%0d res=%0d", tag, resp_id, exp_res);
  endtask

  function automatic logic [15:0] stat(input logic [15:0] n);
`ifdef MULTI_ARB_STATS_EN
    return n;
`else
    return 16'd0 & n;
`endif
  endfunction

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b01;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_id", 32'(resp_id), 32'd0);
    chk("rst.resp_res", 32'(resp_res), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.op_count", 32'(op_count), 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;

    // Single request from requester 0
    req_a = {5'd0, 5'd20};
    req_b = {5'd0, 5'd20};
    op("single", 2'b01, 2'b01, 1'b0, 10'd400);
    req_valid = 2'b00;

    // Requester 1 with maximum operands, then a zero product
    req_a = {5'd31, 5'd0};
    req_b = {5'd31, 5'd0};
    op("max", 2'b10, 2'b10, 1'b1, 10'd961);
    req_a = {5'd1, 5'd0};
    req_b = {5'd0, 5'd0};
    op("zero", 2'b10, 2'b10, 1'b1, 10'd0);
    req_valid = 2'b00;
    chk("stats.three", 32'(op_count), 32'(stat(16'd3)));

    // Reset back to a known pointer before contention
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Both requesters held valid: grants alternate starting at 0
    req_a = {5'd5, 5'd3};
    req_b = {5'd6, 5'd7};
    op("cont0", 2'b11, 2'b01, 1'b0, 10'd21);
    op("cont1", 2'b11, 2'b10, 1'b1, 10'd30);
    op("cont2", 2'b11, 2'b01, 1'b0, 10'd21);
    op("cont3", 2'b11, 2'b10, 1'b1, 10'd30);
    chk("stats.four", 32'(op_count), 32'(stat(16'd4)));

    // Backpressure: response held stable while resp_ready is low
    resp_ready = 1'b0;
    #1;
    chk("bp.ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    chk("bp.valid0", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold_valid", 32'(resp_valid), 32'd1);
      chk("bp.hold_id", 32'(resp_id), 32'd0);
      chk("bp.hold_res", 32'(resp_res), 32'd21);
      chk("bp.hold_ready", 32'(req_ready), 32'd0);
    end
    $display("op bp: held 5 cycles id=%0d res=%0d", resp_id, resp_res);
    resp_ready = 1'b1;
    tick();
    chk("bp.release_valid", 32'(resp_valid), 32'd0);
    chk("bp.release_busy", 32'(busy), 32'd0);
    chk("bp.next_ready", 32'(req_ready), 32'd2);
    chk("stats.five", 32'(op_count), 32'(stat(16'd5)));

    // Grant to requester 1 proceeds into MUL, then reset strikes
    tick();
    chk("mid.busy", 32'(busy), 32'd1);
    chk("mid.valid", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst.resp_id", 32'(resp_id), 32'd0);
    chk("mid_rst.resp_res", 32'(resp_res), 32'd0);
    chk("mid_rst.req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst.op_count", 32'(op_count), 32'd0);
    $display("op mid_rst: outputs cleared");
    @(posedge clk);
    #1;
    rst = 1'b0;
    op("after_rst", 2'b11, 2'b01, 1'b0, 10'd21);
    req_valid = 2'b00;

`ifdef MULTI_ARB_STATS_EN
    // Counter saturation from a preloaded value
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    op("sat0", 2'b01, 2'b01, 1'b0, 10'd21);
    chk("stats.sat0", 32'(op_count), 32'hFFFF);
    op("sat1", 2'b01, 2'b01, 1'b0, 10'd21);
    chk("stats.sat1", 32'(op_count), 32'hFFFF);
    req_valid = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_arbiter.md
# multi_arbiter

Round-robin controller that shares one combinational `multi` unsigned multiplier between NUM_REQ requesters. It accepts one operand pair at a time through a valid/ready handshake, registers the operands and drives them into its `multi` instance. It then registers the product and returns it, tagged with the requester index, on a single response channel that supports backpressure. It sits between the requesting blocks and the multiplier datapath, so no requester connects to `multi` directly.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- WIDTH, 5: operand width; product is 2*WIDTH (5 -> 10, matching `multi`).
- IDW, $clog2(NUM_REQ) (minimum 1): width of resp_id.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NUM_REQ  requester i has an operand pair pending.
- req_a  in  NUM_REQ*WIDTH  operand a of requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand b of requester i, same packing.
- req_ready  out  NUM_REQ  one-hot or zero; req_ready[i] means requester i's pair is accepted this cycle.
- resp_valid  out  1  product available.
- resp_id  out  IDW  index of the requester that owns resp_res.
- resp_res  out  2*WIDTH  a*b, unsigned.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  state != IDLE.
- op_count  out  16  completed-operation counter (see Configuration).

## Operation
- FSM states are IDLE, MUL and RESP.
- IDLE
  - If any req_valid bit is set, select a grant g: the first set bit searching upward from rr_ptr, modulo NUM_REQ.
  - Assert req_ready[g] combinationally in the same cycle.
  - At the clock edge, capture req_a/req_b slice g into op_a/op_b and g into id_q, set rr_ptr <= (g+1) mod NUM_REQ, and go to MUL.
  - If no req_valid bit is set, stay in IDLE with req_ready = 0.
- MUL
  - op_a/op_b drive the `multi` instance.
  - At the edge, capture the product into res_q and go to RESP.
  - req_ready = 0.
- RESP
  - resp_valid = 1; resp_id = id_q; resp_res = res_q.
  - resp_valid, resp_id and resp_res are held stable until resp_ready is high at an edge, then go to IDLE.
  - req_ready = 0.
- Requesters hold req_a/req_b stable while req_valid is high and until req_ready is seen. Dropping req_valid before it is granted is legal.
- req_ready is 0 in every state except IDLE, so only one operation is in flight at any time.
- Arithmetic: full-width unsigned; no truncation, no overflow possible (31*31 = 961 fits in 10 bits).
- Reset, whether idle or mid-operation, has the same effect:
  - state = IDLE, rr_ptr = 0, op_a/op_b/res_q/id_q = 0, op_count = 0.
  - Any in-flight operation is discarded with no response issued.

## Timing
- Output reset values: req_ready = 0, resp_valid = 0, resp_id = 0, resp_res = 0, busy = 0, op_count = 0.
- Acceptance in cycle T (req_valid[g] & req_ready[g]) gives MUL in cycle T+1 and resp_valid = 1 in cycle T+2.
- If resp_ready is high in T+2, IDLE in T+3, where the next grant is possible. Peak throughput is one operation per 3 cycles.
- Backpressure: each cycle with resp_ready low extends RESP by one cycle; outputs do not change.
- resp_ready while resp_valid = 0 is ignored.
- Simultaneous requests are resolved by rr_ptr only. A requester that stays valid is granted within NUM_REQ operations.

## Configuration
- MULTI_ARB_STATS_EN
  - Defined: op_count increments by 1 on each response handshake (resp_valid & resp_ready) and saturates at 16'hFFFF.
  - Undefined: op_count is tied to 16'd0 and no counter flops are built.
  - Port list identical in both builds.

## Structure
- Package multi_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, MUL = 2'd1, RESP = 2'd2);
  - the default WIDTH = 5;
  - the counter width 16 and saturation value.
- One sub-module: the existing `multi` (a, b, res), instantiated once with op_a/op_b.
- The round-robin select is a combinational function inside multi_arbiter, not a separate module.

## Test plan
- Single request: requester 0, a=20, b=20, resp_ready=1 -> req_ready[0] in T, resp_valid in T+2 with resp_res=400, resp_id=0, busy low in T+3.
- Max operands: requester 1, a=31, b=31 -> resp_res=961, resp_id=1. Then a=1, b=0 -> 0.
- Contention: req_valid=2'b11 held for 4 operations after reset -> grant order 0,1,0,1 with correct products per requester (0: 3*7=21, 1: 5*6=30).
- Backpressure: hold resp_ready low for 5 cycles in RESP -> resp_valid, resp_id and resp_res stable, req_ready stays 0 while req_valid=2'b11, single response on release.
- Reset mid-operation: assert reset during MUL -> all outputs 0 immediately (before the next edge), no response appears, next grant after release goes to requester 0.
- Stats: 4 completed operations -> op_count=4 with MULTI_ARB_STATS_EN, 0 without. Preload near saturation (force) -> stays at 65535.
